// File: rtl/ecp5_pipe_lfps_sched_pkg.sv
// rtl/ecp5_pipe_lfps_sched_pkg.sv - shared constants and enums for the PIPE LFPS / receiver-detect scheduler
package ecp5_pipe_pkg;

   localparam logic [1:0] P0 = 2'b00;
   localparam logic [1:0] P1 = 2'b01;
   localparam logic [1:0] P2 = 2'b10;
   localparam logic [1:0] P3 = 2'b11;

   localparam logic [2:0] RXSTAT_RX_PRESENT = 3'b011;

   typedef enum logic [1:0] {IDLE, BURST, GAP, RXDET} sched_state_t;

   typedef enum logic [1:0] {SRC_POLL, SRC_PING, SRC_UEXIT, SRC_RXDET} src_t;

endpackage

// File: rtl/ecp5_pipe_lfps_sched_if.sv
// rtl/ecp5_pipe_lfps_sched_if.sv - LTSSM-side request/result bundle of the LFPS scheduler
interface ecp5_pipe_lfps_sched_if;

   logic        enable;
   logic [1:0]  pwr_state;
   logic        poll_req;
   logic        ping_req;
   logic        uexit_req;
   logic        uexit_stop;
   logic        rxdet_req;
   logic        rxdet_done;
   logic        rxdet_present;
   logic        rxdet_err;
   logic        busy;
   logic [15:0] poll_burst_cnt;

   modport master (
      output enable, pwr_state, poll_req, ping_req, uexit_req, uexit_stop, rxdet_req,
      input  rxdet_done, rxdet_present, rxdet_err, busy, poll_burst_cnt
   );

   modport slave (
      input  enable, pwr_state, poll_req, ping_req, uexit_req, uexit_stop, rxdet_req,
      output rxdet_done, rxdet_present, rxdet_err, busy, poll_burst_cnt
   );

endinterface

// File: rtl/ecp5_pipe_lfps_sched_timer.sv
// rtl/ecp5_pipe_lfps_sched_timer.sv - loadable down-counter; expires at zero and holds there
module pipe_lfps_timer #(
   parameter int CNT_W = 18
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] value,
   output logic             expire
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (value != '0) begin
         value <= value - 1'b1;
      end
   end

   assign expire = (value == '0);

endmodule

// File: rtl/ecp5_pipe_lfps_sched.sv
// rtl/ecp5_pipe_lfps_sched.sv - arbitrates the PIPE transmitter between LFPS bursts and receiver detect
// ECP5_LFPS_STATS_EN defined: poll_burst_cnt counts Polling bursts; otherwise it reads zero.
module ecp5_pipe_lfps_sched
   import ecp5_pipe_pkg::*;
#(
   parameter int POLL_BURST_CYC    = 250,
   parameter int POLL_REPEAT_CYC   = 2500,
   parameter int PING_BURST_CYC    = 25,
   parameter int UEXIT_BURST_CYC   = 20000,
   parameter int RXDET_TIMEOUT_CYC = 1000,
   parameter int CNT_W             = 18
) (
   input  logic                   clk_250mhz,
   input  logic                   phy_reset_n,
   ecp5_pipe_lfps_sched_if.slave  ltssm,
   input  logic                   phy_phy_status_2x,
   input  logic [2:0]             phy_rx_status_2x,
   output logic [1:0]             phy_power_down,
   output logic                   phy_tx_elecidle,
   output logic                   phy_tx_detrx_lpbk
);

   localparam logic [CNT_W-1:0] POLL_LEN  = CNT_W'(POLL_BURST_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LEN   = CNT_W'(POLL_REPEAT_CYC - POLL_BURST_CYC - 1);
   localparam logic [CNT_W-1:0] PING_LEN  = CNT_W'(PING_BURST_CYC - 1);
   localparam logic [CNT_W-1:0] UEXIT_LEN = CNT_W'(UEXIT_BURST_CYC - 1);
   localparam logic [CNT_W-1:0] RXDET_LEN = CNT_W'(RXDET_TIMEOUT_CYC - 1);

   sched_state_t     state_q, state_n;
   src_t             src_q, src_n;
   logic             ping_pend_q, uexit_pend_q, rxdet_pend_q, poll_q;
   logic             ping_pend_n, uexit_pend_n, rxdet_pend_n;
   logic             elecidle_q, elecidle_n, detrx_q, detrx_n;
   logic             done_q, done_n, present_q, present_n, err_q, err_n;
   logic             tmr_load, tmr_expire;
   logic [CNT_W-1:0] tmr_val, tmr_value;
   logic             lfps_ok;

   assign lfps_ok = (ltssm.pwr_state != P0);

   pipe_lfps_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk_250mhz),
      .rst_n    (phy_reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .value    (tmr_value),
      .expire   (tmr_expire)
   );

   always_comb begin
      state_n      = state_q;
      src_n        = src_q;
      elecidle_n   = 1'b1;
      detrx_n      = 1'b0;
      done_n       = 1'b0;
      present_n    = present_q;
      err_n        = err_q;
      tmr_load     = 1'b0;
      tmr_val      = '0;
      ping_pend_n  = ping_pend_q | ltssm.ping_req;
      uexit_pend_n = uexit_pend_q | ltssm.uexit_req;
      rxdet_pend_n = rxdet_pend_q | ltssm.rxdet_req;
      if (!ltssm.enable) begin
         state_n      = IDLE;
         ping_pend_n  = 1'b0;
         uexit_pend_n = 1'b0;
         rxdet_pend_n = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (uexit_pend_q && lfps_ok) begin
                  state_n = BURST; src_n = SRC_UEXIT; elecidle_n = 1'b0;
                  tmr_load = 1'b1; tmr_val = UEXIT_LEN; uexit_pend_n = 1'b0;
               end else if (ping_pend_q && lfps_ok) begin
                  state_n = BURST; src_n = SRC_PING; elecidle_n = 1'b0;
                  tmr_load = 1'b1; tmr_val = PING_LEN; ping_pend_n = 1'b0;
               end else if (rxdet_pend_q) begin
                  rxdet_pend_n = 1'b0;
                  src_n        = SRC_RXDET;
                  // Receiver detect is only meaningful in P2/P3; elsewhere it is refused at once.
                  if (ltssm.pwr_state[1]) begin
                     state_n = RXDET; detrx_n = 1'b1;
                     tmr_load = 1'b1; tmr_val = RXDET_LEN;
                  end else begin
                     done_n = 1'b1; present_n = 1'b0; err_n = 1'b1;
                  end
               end else if (poll_q && lfps_ok) begin
                  state_n = BURST; src_n = SRC_POLL; elecidle_n = 1'b0;
                  tmr_load = 1'b1; tmr_val = POLL_LEN;
               end
            end
            BURST: begin
               if (tmr_expire) begin
                  if (src_q == SRC_POLL) begin
                     state_n = GAP; tmr_load = 1'b1; tmr_val = GAP_LEN;
                  end else begin
                     state_n = IDLE;
                  end
               end else if (src_q == SRC_UEXIT && ltssm.uexit_stop) begin
                  // Squelch now, leave BURST through a zero-length timer on the next edge.
                  tmr_load = 1'b1;
               end else begin
                  elecidle_n = 1'b0;
               end
            end
            GAP: begin
               if (uexit_pend_q || ping_pend_q || rxdet_pend_q || !poll_q) begin
                  state_n = IDLE;
               end else if (tmr_expire) begin
                  state_n = BURST; src_n = SRC_POLL; elecidle_n = 1'b0;
                  tmr_load = 1'b1; tmr_val = POLL_LEN;
               end
            end
            RXDET: begin
               if (phy_phy_status_2x) begin
                  state_n = IDLE; done_n = 1'b1; err_n = 1'b0;
                  present_n = (phy_rx_status_2x == RXSTAT_RX_PRESENT);
               end else if (tmr_expire) begin
                  state_n = IDLE; done_n = 1'b1; err_n = 1'b1; present_n = 1'b0;
               end else begin
                  detrx_n = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_250mhz or negedge phy_reset_n) begin
      if (!phy_reset_n) begin
         state_q        <= IDLE;
         src_q          <= SRC_POLL;
         ping_pend_q    <= 1'b0;
         uexit_pend_q   <= 1'b0;
         rxdet_pend_q   <= 1'b0;
         poll_q         <= 1'b0;
         elecidle_q     <= 1'b1;
         detrx_q        <= 1'b0;
         done_q         <= 1'b0;
         present_q      <= 1'b0;
         err_q          <= 1'b0;
         phy_power_down <= P0;
      end else begin
         state_q        <= state_n;
         src_q          <= src_n;
         ping_pend_q    <= ping_pend_n;
         uexit_pend_q   <= uexit_pend_n;
         rxdet_pend_q   <= rxdet_pend_n;
         poll_q         <= ltssm.poll_req & ltssm.enable;
         elecidle_q     <= elecidle_n;
         detrx_q        <= detrx_n;
         done_q         <= done_n;
         present_q      <= present_n;
         err_q          <= err_n;
         phy_power_down <= ltssm.pwr_state;
      end
   end

`ifdef ECP5_LFPS_STATS_EN
   logic [15:0] poll_cnt_q;
   logic        poll_done;

   assign poll_done = ltssm.enable && (state_q == BURST) && (src_q == SRC_POLL) && tmr_expire;

   always_ff @(posedge clk_250mhz or negedge phy_reset_n) begin
      if (!phy_reset_n) begin
         poll_cnt_q <= '0;
      end else if (!ltssm.enable || !poll_q) begin
         poll_cnt_q <= '0;
      end else if (poll_done && poll_cnt_q != 16'hFFFF) begin
         poll_cnt_q <= poll_cnt_q + 16'd1;
      end
   end

   assign ltssm.poll_burst_cnt = poll_cnt_q;
`else
   assign ltssm.poll_burst_cnt = '0;
`endif

   assign phy_tx_elecidle     = elecidle_q;
   assign phy_tx_detrx_lpbk   = detrx_q;
   assign ltssm.rxdet_done    = done_q;
   assign ltssm.rxdet_present = present_q;
   assign ltssm.rxdet_err     = err_q;
   assign ltssm.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ecp5_pipe_lfps_sched.sv
// tb/tb_ecp5_pipe_lfps_sched.sv - directed vector table plus hand sequences for the LFPS scheduler
module tb_ecp5_pipe_lfps_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       phy_status = 1'b0;
   logic [2:0] phy_rx = 3'b000;
   logic [1:0] power_down;
   logic       elecidle, detrx;
   int         n_chk = 0;
   int         n_fail = 0;

   ecp5_pipe_lfps_sched_if lif();

   ecp5_pipe_lfps_sched dut (
      .clk_250mhz        (clk),
      .phy_reset_n       (rst_n),
      .ltssm             (lif),
      .phy_phy_status_2x (phy_status),
      .phy_rx_status_2x  (phy_rx),
      .phy_power_down    (power_down),
      .phy_tx_elecidle   (elecidle),
      .phy_tx_detrx_lpbk (detrx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] pwr;
      logic       ping, uexit, rxdet;
      int         st_dly;
      logic [2:0] rx;
      int         win;
      int         exp_low, exp_det, exp_done;
      logic       exp_pres, exp_err;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_block();
      @(negedge clk); lif.enable = 1'b0;
      @(negedge clk); lif.enable = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int   low, det, dn, first_low;
      logic pres, err;
      v = vecs[idx];
      low = 0; det = 0; dn = 0; first_low = 0; pres = 1'bx; err = 1'bx;
      @(negedge clk);
      lif.pwr_state = v.pwr; lif.ping_req = v.ping; lif.uexit_req = v.uexit; lif.rxdet_req = v.rxdet;
      @(negedge clk);
      lif.ping_req = 1'b0; lif.uexit_req = 1'b0; lif.rxdet_req = 1'b0;
      for (int c = 1; c <= v.win; c++) begin
         @(negedge clk);
         phy_status = 1'b0;
         if (!elecidle) begin
            low++;
            if (first_low == 0) first_low = c;
         end
         if (detrx) det++;
         if (lif.rxdet_done) begin
            dn++; pres = lif.rxdet_present; err = lif.rxdet_err;
         end
         if (v.st_dly > 0 && detrx && det == v.st_dly) begin
            phy_status = 1'b1; phy_rx = v.rx;
         end
      end
      phy_status = 1'b0;
      chk($sformatf("v%0d low_cycles", idx), low, v.exp_low);
      chk($sformatf("v%0d detrx_cycles", idx), det, v.exp_det);
      chk($sformatf("v%0d done_pulses", idx), dn, v.exp_done);
      if (v.exp_low > 0) chk($sformatf("v%0d grant_latency", idx), first_low, 1);
      if (v.exp_done > 0) begin
         chk($sformatf("v%0d present", idx), {31'd0, pres}, {31'd0, v.exp_pres});
         chk($sformatf("v%0d err", idx), {31'd0, err}, {31'd0, v.exp_err});
      end
      clear_block();
   endtask

   initial begin
      int starts[4];
      int lens[4];
      int nb, dn, low_run;
      logic prev_idle;

      //         pwr   ping  uexit rxdet dly  rx      win    low    det   done pres  err
      vecs[0] = '{2'b01, 1'b1, 1'b0, 1'b0, 0,   3'b000, 40,    25,    0,    0,   1'b0, 1'b0};
      vecs[1] = '{2'b11, 1'b1, 1'b0, 1'b0, 0,   3'b000, 40,    25,    0,    0,   1'b0, 1'b0};
      vecs[2] = '{2'b00, 1'b1, 1'b0, 1'b0, 0,   3'b000, 40,    0,     0,    0,   1'b0, 1'b0};
      vecs[3] = '{2'b11, 1'b0, 1'b0, 1'b1, 300, 3'b011, 320,   0,     300,  1,   1'b1, 1'b0};
      vecs[4] = '{2'b10, 1'b0, 1'b0, 1'b1, 50,  3'b000, 70,    0,     50,   1,   1'b0, 1'b0};
      vecs[5] = '{2'b10, 1'b0, 1'b0, 1'b1, 0,   3'b000, 1020,  0,     1000, 1,   1'b0, 1'b1};
      vecs[6] = '{2'b01, 1'b0, 1'b0, 1'b1, 0,   3'b000, 10,    0,     0,    1,   1'b0, 1'b1};
      vecs[7] = '{2'b10, 1'b0, 1'b1, 1'b0, 0,   3'b000, 20010, 20000, 0,    0,   1'b0, 1'b0};

      lif.enable = 1'b0; lif.pwr_state = 2'b00; lif.poll_req = 1'b0; lif.ping_req = 1'b0;
      lif.uexit_req = 1'b0; lif.uexit_stop = 1'b0; lif.rxdet_req = 1'b0;

      #23;
      chk("rst elecidle", {31'd0, elecidle}, 1);
      chk("rst detrx", {31'd0, detrx}, 0);
      chk("rst power_down", {30'd0, power_down}, 0);
      chk("rst done", {31'd0, lif.rxdet_done}, 0);
      chk("rst present", {31'd0, lif.rxdet_present}, 0);
      chk("rst err", {31'd0, lif.rxdet_err}, 0);
      chk("rst busy", {31'd0, lif.busy}, 0);
      chk("rst poll_cnt", {16'd0, lif.poll_burst_cnt}, 0);
      @(negedge clk); rst_n = 1'b1; lif.enable = 1'b1; lif.pwr_state = 2'b10;
      @(negedge clk);
      chk("power_down follows", {30'd0, power_down}, 2);

      for (int i = 0; i < 8; i++) run_vec(i);

      // ping and rxdet together in P1: ping first, rxdet refused right after
      @(negedge clk); lif.pwr_state = 2'b01; lif.ping_req = 1'b1; lif.rxdet_req = 1'b1;
      @(negedge clk); lif.ping_req = 1'b0; lif.rxdet_req = 1'b0;
      nb = 0; dn = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (!elecidle) nb++;
         if (lif.rxdet_done) begin
            dn = c;
            chk("pair rxdet err", {31'd0, lif.rxdet_err}, 1);
         end
      end
      chk("pair ping low", nb, 25);
      chk("pair done cycle", dn, 27);
      clear_block();

      // P0 keeps an LFPS request pending until a low-power state appears
      @(negedge clk); lif.pwr_state = 2'b00; lif.ping_req = 1'b1;
      @(negedge clk); lif.ping_req = 1'b0;
      repeat (5) @(negedge clk);
      chk("p0 hold elecidle", {31'd0, elecidle}, 1);
      lif.pwr_state = 2'b01;
      @(negedge clk);
      chk("p0 later grant", {31'd0, elecidle}, 0);
      repeat (30) @(negedge clk);
      clear_block();

      // Polling.LFPS repetition
      @(negedge clk); lif.pwr_state = 2'b10; lif.poll_req = 1'b1;
      nb = 0; low_run = 0; prev_idle = 1'b1;
      for (int c = 1; c <= 6250; c++) begin
         @(negedge clk);
         if (!elecidle) begin
            if (prev_idle && nb < 4) starts[nb] = c;
            low_run++;
         end else if (!prev_idle) begin
            if (nb < 4) lens[nb] = low_run;
            nb++; low_run = 0;
         end
         prev_idle = elecidle;
      end
      chk("poll bursts", nb, 3);
      chk("poll first start", starts[0], 2);
      for (int i = 0; i < 3; i++) chk($sformatf("poll len%0d", i), lens[i], 250);
      chk("poll repeat 1", starts[1] - starts[0], 2500);
      chk("poll repeat 2", starts[2] - starts[1], 2500);
`ifdef ECP5_LFPS_STATS_EN
      chk("poll_cnt", {16'd0, lif.poll_burst_cnt}, 3);
`else
      chk("poll_cnt", {16'd0, lif.poll_burst_cnt}, 0);
`endif
      lif.poll_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("poll drop busy", {31'd0, lif.busy}, 0);
      chk("poll drop cnt", {16'd0, lif.poll_burst_cnt}, 0);

      // GAP yields to a U-exit request
      lif.poll_req = 1'b1;
      repeat (400) @(negedge clk);
      lif.uexit_req = 1'b1;
      @(negedge clk); lif.uexit_req = 1'b0;
      chk("gap still busy", {31'd0, lif.busy}, 1);
      @(negedge clk);
      chk("gap exits", {31'd0, lif.busy}, 0);
      @(negedge clk);
      chk("gap uexit burst", {31'd0, elecidle}, 0);
      lif.poll_req = 1'b0;
      lif.uexit_stop = 1'b1;
      repeat (4) @(negedge clk);
      lif.uexit_stop = 1'b0;
      chk("gap settle", {31'd0, lif.busy}, 0);
      clear_block();

      // U-exit ended early by the far end
      @(negedge clk); lif.pwr_state = 2'b01; lif.uexit_req = 1'b1;
      @(negedge clk); lif.uexit_req = 1'b0;
      nb = 0;
      for (int c = 1; c <= 500; c++) begin
         @(negedge clk);
         if (!elecidle) nb++;
      end
      chk("stop low cycles", nb, 500);
      lif.uexit_stop = 1'b1;
      @(negedge clk); lif.uexit_stop = 1'b0;
      chk("stop elecidle", {31'd0, elecidle}, 1);
      chk("stop busy held", {31'd0, lif.busy}, 1);
      @(negedge clk);
      chk("stop busy clear", {31'd0, lif.busy}, 0);
      clear_block();

      // enable dropped mid-burst and mid-detect
      @(negedge clk); lif.uexit_req = 1'b1;
      @(negedge clk); lif.uexit_req = 1'b0;
      repeat (100) @(negedge clk);
      lif.enable = 1'b0;
      @(negedge clk);
      chk("abort elecidle", {31'd0, elecidle}, 1);
      chk("abort busy", {31'd0, lif.busy}, 0);
      lif.enable = 1'b1;
      @(negedge clk); lif.pwr_state = 2'b11; lif.rxdet_req = 1'b1;
      @(negedge clk); lif.rxdet_req = 1'b0;
      repeat (50) @(negedge clk);
      lif.enable = 1'b0;
      dn = 0;
      @(negedge clk);
      chk("abort detrx", {31'd0, detrx}, 0);
      for (int c = 0; c < 5; c++) begin
         if (lif.rxdet_done) dn++;
         @(negedge clk);
      end
      chk("abort no done", dn, 0);
      lif.enable = 1'b1;
      repeat (2) @(negedge clk);

      // asynchronous reset in the middle of a burst
      lif.pwr_state = 2'b01; lif.uexit_req = 1'b1;
      @(negedge clk); lif.uexit_req = 1'b0;
      repeat (50) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst elecidle", {31'd0, elecidle}, 1);
      chk("async rst busy", {31'd0, lif.busy}, 0);
      chk("async rst power_down", {30'd0, power_down}, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post rst idle", {31'd0, elecidle}, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
